sweep_sequencer: RTL and testbench

SWEEP_SEQUENCER -- requirements
Module: sweep_sequencer

---
 rtl/sweep_sequencer.sv | 72 +++++++
 tb/tb_sweep_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sweep_sequencer.sv
// sweep_sequencer: steps a code from start to end, settling a timer and requesting a sample per point.
// Optional abort input is enabled with `define SWEEP_SEQUENCER_ABORT_EN.
module sweep_sequencer #(
  parameter int CNT_WIDTH  = 4,
  parameter int CODE_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_sync,
  input  logic                  i_start,
  input  logic [CODE_WIDTH-1:0] i_code_start,
  input  logic [CODE_WIDTH-1:0] i_code_end,
  input  logic [CODE_WIDTH-1:0] i_code_step,
  input  logic [CNT_WIDTH-1:0]  i_settle_cnt,
  input  logic                  i_timer_done,
  input  logic                  i_sample_ack,
`ifdef SWEEP_SEQUENCER_ABORT_EN
  input  logic                  i_abort,
`endif
  output logic [CNT_WIDTH-1:0]  o_timer_cnt,
  output logic                  o_timer_update,
  output logic [CODE_WIDTH-1:0] o_code,
  output logic                  o_sample_req,
  output logic                  o_busy,
  output logic                  o_done
);
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, SAMPLE, STEP, DONE} state_t;
  state_t state, next_state;
  logic [CODE_WIDTH-1:0] end_r, step_r;
  logic [CODE_WIDTH:0]   nxt;
  logic                  fresh, stop;
  assign o_timer_update = state == LOAD;
  assign o_sample_req   = state == SAMPLE;
  assign o_busy         = state inside {LOAD, SETTLE, SAMPLE, STEP};
  assign o_done         = state == DONE;
  always_comb begin
    nxt  = {1'b0, o_code} + {1'b0, (step_r == '0) ? CODE_WIDTH'(1) : step_r};
    stop = nxt[CODE_WIDTH] || (nxt[CODE_WIDTH-1:0] > end_r);
    next_state = IDLE;
    unique case (state)
      IDLE:    next_state = i_start ? LOAD : IDLE;
      LOAD:    next_state = SETTLE;
      SETTLE:  next_state = (!fresh && i_timer_done) ? SAMPLE : SETTLE;
      SAMPLE:  next_state = i_sample_ack ? STEP : SAMPLE;
      STEP:    next_state = stop ? DONE : LOAD;
      default: next_state = IDLE;
    endcase
`ifdef SWEEP_SEQUENCER_ABORT_EN
    if (i_abort && o_busy) next_state = DONE;
`endif
  end
  // fresh marks the first SETTLE cycle, where a done left over from the previous point is stale
  always_ff @(posedge i_clk) begin
    if (i_rst_sync) begin
      state       <= IDLE;
      o_code      <= '0;
      o_timer_cnt <= '0;
      end_r       <= '0;
      step_r      <= '0;
      fresh       <= 1'b0;
    end else begin
      state <= next_state;
      fresh <= state == LOAD;
      if (state == IDLE && i_start) begin
        o_code      <= i_code_start;
        end_r       <= i_code_end;
        step_r      <= i_code_step;
        o_timer_cnt <= i_settle_cnt;
      end
      if (state == STEP && next_state == LOAD) o_code <= nxt[CODE_WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_sweep_sequencer.sv
// tb_sweep_sequencer: directed checks of the sweep sequencer with a timer and sample-ack model.
module tb_sweep_sequencer;
  logic clk = 0;
  always #5 clk = ~clk;
  logic       rst, start, timer_done, ack;
  logic [7:0] code_start, code_end, code_step;
  logic [3:0] settle;
  logic [3:0] timer_cnt;
  logic       timer_update, sample_req, busy, done;
  logic [7:0] code;
`ifdef SWEEP_SEQUENCER_ABORT_EN
  logic abort;
`endif
  sweep_sequencer dut (
    .i_clk(clk), .i_rst_sync(rst), .i_start(start),
    .i_code_start(code_start), .i_code_end(code_end), .i_code_step(code_step),
    .i_settle_cnt(settle), .i_timer_done(timer_done), .i_sample_ack(ack),
`ifdef SWEEP_SEQUENCER_ABORT_EN
    .i_abort(abort),
`endif
    .o_timer_cnt(timer_cnt), .o_timer_update(timer_update), .o_code(code),
    .o_sample_req(sample_req), .o_busy(busy), .o_done(done)
  );
  int n_cmp = 0, n_err = 0;
  int samp_q[$], upd_q[$];
  int done_n = 0, viol = 0, scnt = 0, ack_dly = 0, tcnt = 0, cyc;
  bit hold = 0;
  logic prev_req = 0;
  logic [7:0] prev_code = 0;
  // Timer and sampler model, evaluated away from the active edge
  always @(negedge clk) begin
    if (timer_update === 1'b1) begin
      tcnt = int'(timer_cnt);
      upd_q.push_back(int'(timer_cnt));
    end else if (tcnt > 0) tcnt--;
    timer_done = hold || tcnt == 0;
    if (sample_req === 1'b1) begin
      ack = scnt >= ack_dly;
      scnt++;
    end else begin
      ack = 0;
      scnt = 0;
    end
    if (sample_req === 1'b1 && prev_req && code !== prev_code) viol++;
    if (sample_req === 1'b1 && ack) samp_q.push_back(int'(code));
    if (done === 1'b1) done_n++;
    prev_req = sample_req === 1'b1;
    prev_code = code;
  end
  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic int sq(input int i);
    return i < samp_q.size() ? samp_q[i] : -1;
  endfunction
  function automatic int uq(input int i);
    return i < upd_q.size() ? upd_q[i] : -1;
  endfunction
  task automatic launch(input logic [7:0] s, input logic [7:0] e, input logic [7:0] st, input logic [3:0] cnt);
    samp_q.delete();
    upd_q.delete();
    done_n = 0;
    viol = 0;
    code_start = s;
    code_end = e;
    code_step = st;
    settle = cnt;
    start = 1;
    cyc = 1;
    @(negedge clk);
    cyc++;
    start = 0;
    code_start = 8'h33;
    code_end = 8'h01;
    code_step = 8'h00;
    settle = 4'hf;
  endtask
  task automatic run(input logic [7:0] s, input logic [7:0] e, input logic [7:0] st, input logic [3:0] cnt);
    launch(s, e, st, cnt);
    while (done !== 1'b1 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", int'(done), 1);
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);
    check("idle_not_busy", int'(busy), 0);
    check("done_pulses", done_n, 1);
    check("code_stable", viol, 0);
  endtask
  initial begin
    rst = 1;
    start = 0;
    code_start = 0;
    code_end = 0;
    code_step = 0;
    settle = 0;
`ifdef SWEEP_SEQUENCER_ABORT_EN
    abort = 0;
`endif
    repeat (2) @(negedge clk);
    check("rst_code", int'(code), 0);
    check("rst_tcnt", int'(timer_cnt), 0);
    check("rst_upd", int'(timer_update), 0);
    check("rst_req", int'(sample_req), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst = 0;
    @(negedge clk);
    run(8'd2, 8'd8, 8'd3, 4'd5);
    check("t1_cycles", cyc, 26);
    check("t1_nsamp", samp_q.size(), 3);
    check("t1_s0", sq(0), 2);
    check("t1_s1", sq(1), 5);
    check("t1_s2", sq(2), 8);
    check("t1_nupd", upd_q.size(), 3);
    check("t1_u0", uq(0), 5);
    check("t1_u1", uq(1), 5);
    check("t1_u2", uq(2), 5);
    run(8'd254, 8'd255, 8'd0, 4'd2);
    check("t2_cycles", cyc, 12);
    check("t2_nsamp", samp_q.size(), 2);
    check("t2_s0", sq(0), 254);
    check("t2_s1", sq(1), 255);
    check("t2_code_end", int'(code), 255);
    run(8'd10, 8'd4, 8'd1, 4'd3);
    check("t3_cycles", cyc, 8);
    check("t3_nsamp", samp_q.size(), 1);
    check("t3_s0", sq(0), 10);
    hold = 1;
    ack_dly = 7;
    @(negedge clk);
    run(8'd1, 8'd2, 8'd1, 4'd5);
    check("t4_cycles", cyc, 26);
    check("t4_nsamp", samp_q.size(), 2);
    check("t4_s0", sq(0), 1);
    check("t4_s1", sq(1), 2);
    hold = 0;
    ack_dly = 100;
    launch(8'd3, 8'd9, 8'd1, 4'd2);
    while (sample_req !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("t5_in_sample", int'(sample_req), 1);
    rst = 1;
    @(negedge clk);
    check("t5_code", int'(code), 0);
    check("t5_tcnt", int'(timer_cnt), 0);
    check("t5_upd", int'(timer_update), 0);
    check("t5_req", int'(sample_req), 0);
    check("t5_busy", int'(busy), 0);
    check("t5_done", int'(done), 0);
    rst = 0;
    repeat (5) @(negedge clk);
    check("t5_no_done", done_n, 0);
    check("t5_idle", int'(busy), 0);
    ack_dly = 0;
`ifdef SWEEP_SEQUENCER_ABORT_EN
    launch(8'd5, 8'd20, 8'd1, 4'd5);
    check("t6_load", int'(timer_update), 1);
    @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("t6_done", int'(done), 1);
    check("t6_code", int'(code), 5);
    @(negedge clk);
    check("t6_done_end", int'(done), 0);
    check("t6_idle", int'(busy), 0);
    check("t6_pulses", done_n, 1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
